cla_pipe_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath arithmetic library. It is the next generation of the registered 6-bit CLA and adds the following:
- Configurable width and lookahead group size.
- A subtract mode.
- Signed-overflow and zero flags.
- A valid/ready handshake on both sides with full-pipeline stall.

One lookahead group is resolved per pipeline stage, so throughput is one operation per clock at any width.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_pipe_addsub_if.sv | 30 +++
 rtl/cla_group.sv | 51 +++++
 rtl/cla_pipe_addsub.sv | 123 ++++++++++++
 tb/tb_cla_pipe_addsub.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// operation encoding, group-count helper and parameter legality check.
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;
    localparam int GROUP_MIN = 2;
    localparam int GROUP_MAX = 8;

    // Number of lookahead groups, which is also the pipeline depth.
    function automatic int cla_ngroups(input int width, input int group);
        return width / group;
    endfunction

    // True when the width/group combination is one the pipeline supports.
    function automatic bit cla_params_ok(input int width, input int group);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
               (group >= GROUP_MIN) && (group <= GROUP_MAX) &&
               ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub. The slave side is the
// adder itself; the master side is whoever feeds operands and drains results.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic             c_in;
    logic             sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in_A, in_B, c_in, sub, out_ready,
        input  in_ready, out_valid, out, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, in_A, in_B, c_in, sub, out_ready,
        output in_ready, out_valid, out, c_out, ovf, zero
    );

endinterface

// File: rtl/cla_group.sv
// One carry-lookahead group: every internal carry is a flat sum of products
// of generate/propagate terms and the group carry-in, so the logic depth is
// fixed by GROUP and independent of where the group sits in the word.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // c[i] = cin&p[0..i-1] | sum over j of g[j]&p[j+1..i-1]
    always_comb begin
        logic term;
        logic acc;
        term = 1'b0;
        acc  = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int i = 1; i <= GROUP; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & p[k];
            end
            acc = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i] = acc;
        end
    end

    assign sum   = p ^ c[GROUP-1:0];
    assign cout  = c[GROUP];
    assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Stage k resolves lookahead
// group k-1; finished low sum bits and still-unused high operand bits ride
// forward in the stage registers so every result leaves fully aligned.
// A stalled output freezes the whole pipeline, bubbles included.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic              CLK,
    input logic              CLR_,
    cla_pipe_addsub_if.slave bus
);

    localparam int NG = cla_ngroups(WIDTH, GROUP);

    if (!cla_params_ok(WIDTH, GROUP)) begin : g_param_check
        $error("cla_pipe_addsub: WIDTH must be 4..64, GROUP 2..8, WIDTH a multiple of GROUP");
    end

    // Stage registers, index k = stage that resolves group k-1.
    logic [WIDTH-1:0] a_p   [1:NG];
    logic [WIDTH-1:0] b_p   [1:NG];
    logic [WIDTH-1:0] sum_p [1:NG];
    logic             cy_p  [1:NG];
    logic             vld_p [1:NG];

    // Per-group combinational results and the sum as seen after each stage.
    logic [GROUP-1:0] grp_sum  [0:NG-1];
    logic             grp_cout [0:NG-1];
    logic             grp_cmsb [0:NG-1];
    logic [WIDTH-1:0] asm_sum  [1:NG];

    // Output register.
    logic [WIDTH-1:0] out_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_vld_q;

    logic             stall;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    assign stall        = out_vld_q && !bus.out_ready;
    assign bus.in_ready = !stall;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a     (a_p[gi+1][gi*GROUP +: GROUP]),
            .b     (b_p[gi+1][gi*GROUP +: GROUP]),
            .cin   (cy_p[gi+1]),
            .sum   (grp_sum[gi]),
            .cout  (grp_cout[gi]),
            .c_msb (grp_cmsb[gi])
        );
    end

    // Merge each stage's freshly computed group into the bits already done.
    always_comb begin
        for (int k = 1; k <= NG; k++) begin
            asm_sum[k] = sum_p[k];
            asm_sum[k][(k-1)*GROUP +: GROUP] = grp_sum[k-1];
        end
    end

    // Datapath stage registers: capture operands, then shift one group per clock.
    always_ff @(posedge CLK) begin
        if (!stall) begin
            a_p[1]   <= bus.in_A;
            b_p[1]   <= (bus.sub == OP_SUB) ? ~bus.in_B : bus.in_B;
            cy_p[1]  <= (bus.sub == OP_SUB) ? 1'b1 : bus.c_in;
            sum_p[1] <= '0;
            for (int k = 1; k < NG; k++) begin
                a_p[k+1]   <= a_p[k];
                b_p[k+1]   <= b_p[k];
                sum_p[k+1] <= asm_sum[k];
                cy_p[k+1]  <= grp_cout[k-1];
            end
        end
    end

    // Valid pipeline: cleared asynchronously, advances with bubbles unless stalled.
    always_ff @(posedge CLK or negedge CLR_) begin
        if (!CLR_) begin
            for (int k = 1; k <= NG; k++) begin
                vld_p[k] <= 1'b0;
            end
            out_vld_q <= 1'b0;
        end else if (!stall) begin
            vld_p[1] <= bus.in_valid;
            for (int k = 1; k < NG; k++) begin
                vld_p[k+1] <= vld_p[k];
            end
            out_vld_q <= vld_p[NG];
        end
    end

    // Output register: aligned sum, carry-out and flags from the last group.
    always_ff @(posedge CLK or negedge CLR_) begin
        if (!CLR_) begin
            out_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (!stall) begin
            out_q   <= asm_sum[NG];
            c_out_q <= grp_cout[NG-1];
            ovf_q   <= grp_cmsb[NG-1] ^ grp_cout[NG-1];
            zero_q  <= is_zero(asm_sum[NG]);
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out       = out_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: four instances (16/4, 8/2, 32/8, 64/4) share a
// clock and reset; each is driven through 64-bit staging arrays so the same
// scoreboard tasks serve every width.
module tb_cla_pipe_addsub;

    typedef struct packed {
        logic [63:0] res;
        logic        co;
        logic        ov;
        logic        z;
        int          acc;
    } exp_t;

    logic clk;
    logic clr_;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    logic        iv_d [4];
    logic [63:0] a_d  [4];
    logic [63:0] b_d  [4];
    logic        ci_d [4];
    logic        sb_d [4];
    logic        or_d [4];

    logic        ir_o  [4];
    logic        ov_o  [4];
    logic [63:0] out_o [4];
    logic        co_o  [4];
    logic        of_o  [4];
    logic        z_o   [4];

    cla_pipe_addsub_if #(.WIDTH(16)) bus0 ();
    cla_pipe_addsub_if #(.WIDTH(8))  bus1 ();
    cla_pipe_addsub_if #(.WIDTH(32)) bus2 ();
    cla_pipe_addsub_if #(.WIDTH(64)) bus3 ();

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) u_dut0 (.CLK(clk), .CLR_(clr_), .bus(bus0));
    cla_pipe_addsub #(.WIDTH(8),  .GROUP(2)) u_dut1 (.CLK(clk), .CLR_(clr_), .bus(bus1));
    cla_pipe_addsub #(.WIDTH(32), .GROUP(8)) u_dut2 (.CLK(clk), .CLR_(clr_), .bus(bus2));
    cla_pipe_addsub #(.WIDTH(64), .GROUP(4)) u_dut3 (.CLK(clk), .CLR_(clr_), .bus(bus3));

    assign bus0.in_valid = iv_d[0]; assign bus0.in_A = a_d[0][15:0]; assign bus0.in_B = b_d[0][15:0];
    assign bus0.c_in = ci_d[0]; assign bus0.sub = sb_d[0]; assign bus0.out_ready = or_d[0];
    assign ir_o[0] = bus0.in_ready; assign ov_o[0] = bus0.out_valid; assign out_o[0] = 64'(bus0.out);
    assign co_o[0] = bus0.c_out; assign of_o[0] = bus0.ovf; assign z_o[0] = bus0.zero;

    assign bus1.in_valid = iv_d[1]; assign bus1.in_A = a_d[1][7:0]; assign bus1.in_B = b_d[1][7:0];
    assign bus1.c_in = ci_d[1]; assign bus1.sub = sb_d[1]; assign bus1.out_ready = or_d[1];
    assign ir_o[1] = bus1.in_ready; assign ov_o[1] = bus1.out_valid; assign out_o[1] = 64'(bus1.out);
    assign co_o[1] = bus1.c_out; assign of_o[1] = bus1.ovf; assign z_o[1] = bus1.zero;

    assign bus2.in_valid = iv_d[2]; assign bus2.in_A = a_d[2][31:0]; assign bus2.in_B = b_d[2][31:0];
    assign bus2.c_in = ci_d[2]; assign bus2.sub = sb_d[2]; assign bus2.out_ready = or_d[2];
    assign ir_o[2] = bus2.in_ready; assign ov_o[2] = bus2.out_valid; assign out_o[2] = 64'(bus2.out);
    assign co_o[2] = bus2.c_out; assign of_o[2] = bus2.ovf; assign z_o[2] = bus2.zero;

    assign bus3.in_valid = iv_d[3]; assign bus3.in_A = a_d[3]; assign bus3.in_B = b_d[3];
    assign bus3.c_in = ci_d[3]; assign bus3.sub = sb_d[3]; assign bus3.out_ready = or_d[3];
    assign ir_o[3] = bus3.in_ready; assign ov_o[3] = bus3.out_valid; assign out_o[3] = bus3.out;
    assign co_o[3] = bus3.c_out; assign of_o[3] = bus3.ovf; assign z_o[3] = bus3.zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "time limit");
    end

    // Reference result built with plain integer addition on a 65-bit word.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic s, input int acc);
        logic [63:0] mask;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [64:0] full;
        exp_t        e;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa     = a & mask;
        bb     = (s ? ~b : b) & mask;
        full   = {1'b0, aa} + {1'b0, bb} + 65'(s ? 1'b1 : ci);
        e.res  = full[63:0] & mask;
        e.co   = full[w];
        e.ov   = (aa[w-1] == bb[w-1]) && (e.res[w-1] != aa[w-1]);
        e.z    = (e.res == 64'd0);
        e.acc  = acc;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        clr_ = 1'b1;
        #1;
        clr_ = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov_o[i] !== 1'b0 || out_o[i] !== 64'd0 || co_o[i] !== 1'b0 || of_o[i] !== 1'b0 ||
                z_o[i] !== 1'b0 || ir_o[i] !== 1'b1) begin
                failures++;
                $display("FAIL reset_powerup dut%0d: out_valid=%b out=%h c_out=%b ovf=%b zero=%b in_ready=%b, want 0 0 0 0 0 1",
                         i, ov_o[i], out_o[i], co_o[i], of_o[i], z_o[i], ir_o[i]);
            end
        end
        step();
        step();
        clr_ = 1'b1;

        or_d[0] = 1'b0; sb_d[0] = 1'b0; ci_d[0] = 1'b0; iv_d[0] = 1'b1;
        a_d[0] = 64'h8000; b_d[0] = 64'h8001; step();
        a_d[0] = 64'h1234; b_d[0] = 64'h1111; step();
        a_d[0] = 64'h0F0F; b_d[0] = 64'h00F1; step();
        iv_d[0] = 1'b0;
        n = 0;
        while (ov_o[0] !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (ov_o[0] !== 1'b1 || out_o[0] !== 64'h0001 || co_o[0] !== 1'b1 || of_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_result: out_valid=%b out=%h c_out=%b ovf=%b, want 1 0001 1 1",
                     ov_o[0], out_o[0], co_o[0], of_o[0]);
        end
        checks++;
        if (ir_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready: in_ready=%b, want 0", ir_o[0]);
        end
        #2;
        clr_ = 1'b0;
        #1;
        checks++;
        if (ov_o[0] !== 1'b0 || out_o[0] !== 64'd0 || co_o[0] !== 1'b0 || of_o[0] !== 1'b0 ||
            z_o[0] !== 1'b0 || ir_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: out_valid=%b out=%h c_out=%b ovf=%b zero=%b in_ready=%b, want 0 0 0 0 0 1",
                     ov_o[0], out_o[0], co_o[0], of_o[0], z_o[0], ir_o[0]);
        end
        step();
        step();
        clr_ = 1'b1;
        or_d[0] = 1'b1;
        #1;
        checks++;
        if (ir_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b, want 1", ir_o[0]);
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (ov_o[0] !== 1'b0) n++;
            step();
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL reset_leak: out_valid seen %0d cycles after reset, want 0", n);
        end
    endtask

    task automatic test_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic s, input logic [15:0] eo,
                            input logic eco, input logic eov, input logic ez);
        int lat;
        a_d[0] = 64'(a); b_d[0] = 64'(b); ci_d[0] = ci; sb_d[0] = s;
        or_d[0] = 1'b1; iv_d[0] = 1'b1;
        #1;
        checks++;
        if (ir_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready: in_ready=%b, want 1", tag, ir_o[0]);
        end
        step();
        iv_d[0] = 1'b0;
        lat = 0;
        while (ov_o[0] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL %s_latency: got %0d edges, want 4", tag, lat);
        end
        checks++;
        if (out_o[0] !== 64'(eo) || co_o[0] !== eco || of_o[0] !== eov || z_o[0] !== ez) begin
            failures++;
            $display("FAIL %s: out=%h c_out=%b ovf=%b zero=%b, want out=%h c_out=%b ovf=%b zero=%b",
                     tag, out_o[0], co_o[0], of_o[0], z_o[0], eo, eco, eov, ez);
        end
        step();
    endtask

    task automatic test_carry_chain();
        test_vec("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_add_overflow();
        test_vec("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_subtract();
        test_vec("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        test_vec("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        test_vec("sub_cin_ignored", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    endtask

    // Back-to-back random beats against the scoreboard, with optional random backpressure.
    task automatic run_stream(input string tag, input int idx, input int w, input int ng,
                              input int nbeats, input int rdy_pct, input bit chk_lat);
        logic [63:0] mask;
        logic        exp_rdy;
        exp_t        e;
        int          sent, got, budget, extra;
        bit          need_new, stalled;
        mask     = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        exp_q.delete();
        sent     = 0;
        got      = 0;
        extra    = 0;
        budget   = nbeats * 20 + 100;
        need_new = 1'b1;
        stalled  = 1'b0;
        while (got < nbeats && budget > 0) begin
            if (need_new) begin
                a_d[idx]  = {$urandom, $urandom} & mask;
                b_d[idx]  = {$urandom, $urandom} & mask;
                if ($urandom_range(7) == 0) a_d[idx] = mask;
                if ($urandom_range(7) == 0) b_d[idx] = 64'd1 << (w - 1);
                ci_d[idx] = 1'($urandom_range(1));
                sb_d[idx] = 1'($urandom_range(1));
                need_new  = 1'b0;
            end
            iv_d[idx] = (sent < nbeats);
            or_d[idx] = ($urandom_range(99) < rdy_pct);
            #1;
            exp_rdy = !((ov_o[idx] === 1'b1) && !or_d[idx]);
            checks++;
            if (ir_o[idx] !== exp_rdy) begin
                failures++;
                $display("FAIL %s_in_ready cyc=%0d: in_ready=%b, want %b", tag, cyc, ir_o[idx], exp_rdy);
            end
            if (stalled) begin
                checks++;
                if (ov_o[idx] !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_hold_valid cyc=%0d: out_valid=%b, want 1", tag, cyc, ov_o[idx]);
                end
            end
            if (ov_o[idx] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_extra cyc=%0d: out_valid=1 out=%h, want no result", tag, cyc, out_o[idx]);
                end else begin
                    e = exp_q[0];
                    checks++;
                    if (out_o[idx] !== e.res || co_o[idx] !== e.co || of_o[idx] !== e.ov || z_o[idx] !== e.z) begin
                        failures++;
                        $display("FAIL %s_result cyc=%0d: out=%h c_out=%b ovf=%b zero=%b, want out=%h c_out=%b ovf=%b zero=%b",
                                 tag, cyc, out_o[idx], co_o[idx], of_o[idx], z_o[idx], e.res, e.co, e.ov, e.z);
                    end
                    if (chk_lat) begin
                        checks++;
                        if (cyc - e.acc != ng) begin
                            failures++;
                            $display("FAIL %s_latency: got %0d edges, want %0d", tag, cyc - e.acc, ng);
                        end
                    end
                    if (or_d[idx]) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            stalled = (ov_o[idx] === 1'b1) && !or_d[idx];
            if (iv_d[idx] && ir_o[idx] === 1'b1) begin
                exp_q.push_back(model(w, a_d[idx], b_d[idx], ci_d[idx], sb_d[idx], cyc + 1));
                sent++;
                need_new = 1'b1;
            end
            step();
            budget--;
        end
        checks++;
        if (got != nbeats) begin
            failures++;
            $display("FAIL %s_count: got %0d results, want %0d", tag, got, nbeats);
        end
        iv_d[idx] = 1'b0;
        or_d[idx] = 1'b1;
        for (int i = 0; i < 2 * ng + 4; i++) begin
            #1;
            if (ov_o[idx] !== 1'b0) extra++;
            step();
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL %s_dup: %0d extra results after drain, want 0", tag, extra);
        end
    endtask

    task automatic test_backpressure();
        run_stream("stream16", 0, 16, 4, 16, 50, 1'b0);
        run_stream("stream8", 1, 8, 4, 40, 30, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_stream("b2b16", 0, 16, 4, 64, 100, 1'b1);
    endtask

    task automatic test_param_sweep();
        run_stream("sweep8_2", 1, 8, 4, 1000, 100, 1'b1);
        run_stream("sweep32_8", 2, 32, 4, 1000, 100, 1'b1);
        run_stream("sweep64_4", 3, 64, 16, 1000, 100, 1'b1);
    endtask

    initial begin
        clr_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv_d[i] = 1'b0; a_d[i] = 64'd0; b_d[i] = 64'd0;
            ci_d[i] = 1'b0; sb_d[i] = 1'b0; or_d[i] = 1'b1;
        end
        test_reset();
        test_carry_chain();
        test_add_overflow();
        test_subtract();
        test_backpressure();
        test_back_to_back();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
